// File: rtl/cache_pkg.sv
// Shared types and width helpers for the cache line-fill controller.
// Widths derive from the module parameters, so they are exposed as constant functions.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } fill_state_e;

  // Bits needed to index a word within a line.
  function automatic int word_idx_w(input int line_words);
    return $clog2(line_words);
  endfunction

  // Byte-offset bits below the word index; zero when words are single bytes.
  function automatic int byte_off_w(input int word_bytes);
    return $clog2(word_bytes);
  endfunction

endpackage

// File: rtl/wrap_counter.sv
// Fill progress counter: counts up to LINE_WORDS and reports the word slot
// reached when starting from an arbitrary word and wrapping around the line.
module wrap_counter
  import cache_pkg::*;
#(
  parameter  int LINE_WORDS = 8,
  localparam int IW         = word_idx_w(LINE_WORDS),
  localparam int CW         = IW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clr,
  input  logic [IW-1:0] start,
  output logic [CW-1:0] count,
  output logic [IW-1:0] idx
);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  // The index drops the carry bit, which is exactly the modulo-LINE_WORDS wrap.
  assign idx   = start + count_q[IW-1:0];

endmodule

// File: rtl/cache_fill_ctrl.sv
// Cache line-fill controller: on a miss, streams LINE_WORDS word requests to
// memory back-to-back, writes returned words in issue order, then writes the tag.
module cache_fill_ctrl
  import cache_pkg::*;
#(
  parameter  int ADDR_W     = 16,
  parameter  int LINE_WORDS = 8,
  parameter  int WORD_BYTES = 2,
  parameter  int CWF        = 0,
  localparam int IW         = word_idx_w(LINE_WORDS),
  localparam int CW         = IW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_address,
  input  logic              memory_data_valid,
  output logic              fsm_busy,
  output logic [ADDR_W-1:0] memory_address,
  output logic              mem_req,
  output logic              write_data_array,
  output logic [IW-1:0]     data_word_sel,
  output logic              write_tag_array,
  output fill_state_e       dbg_state
);

  localparam int              OFF_W     = byte_off_w(WORD_BYTES);
  localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(LINE_WORDS * WORD_BYTES - 1);
  localparam logic [CW-1:0]   LW_CNT    = CW'(LINE_WORDS);
  localparam logic [CW-1:0]   LW_LAST   = CW'(LINE_WORDS - 1);

  fill_state_e       state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [IW-1:0]     start_q, start_d;

  logic [CW-1:0] req_cnt, resp_cnt;
  logic [IW-1:0] req_idx, resp_idx;
  logic          req_en, resp_en, last_resp, cnt_clr;

  // Requests free-run ahead of responses; both stop once the line is covered.
  assign req_en    = (state_q == FILL) && (req_cnt != LW_CNT);
  assign resp_en   = (state_q == FILL) && memory_data_valid && (resp_cnt != LW_CNT);
  assign last_resp = resp_en && (resp_cnt == LW_LAST);
  assign cnt_clr   = (state_q != FILL);

  wrap_counter #(.LINE_WORDS(LINE_WORDS)) u_req_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (req_en),
    .clr   (cnt_clr),
    .start (start_q),
    .count (req_cnt),
    .idx   (req_idx)
  );

  wrap_counter #(.LINE_WORDS(LINE_WORDS)) u_resp_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (resp_en),
    .clr   (cnt_clr),
    .start (start_q),
    .count (resp_cnt),
    .idx   (resp_idx)
  );

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    start_d = start_q;
    unique case (state_q)
      IDLE: begin
        if (miss_detected) begin
          state_d = FILL;
          base_d  = miss_address & ~LINE_MASK;
          start_d = (CWF != 0) ? IW'(miss_address >> OFF_W) : '0;
        end
      end
      FILL:    if (last_resp) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      base_q  <= '0;
      start_q <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      start_q <= start_d;
    end
  end

  // Outputs decode registered state only, so reset clears them without a clock edge.
  assign fsm_busy         = (state_q != IDLE);
  assign mem_req          = req_en;
  assign memory_address   = req_en ? (base_q | (ADDR_W'(req_idx) << OFF_W)) : '0;
  assign write_data_array = resp_en;
  assign data_word_sel    = resp_en ? resp_idx : '0;
  assign write_tag_array  = (state_q == DONE);
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Randomized bench for cache_fill_ctrl: ascending-order and critical-word-first
// instances share one stimulus stream and are checked against a fill-level model.
module tb_cache_fill_ctrl;
  import cache_pkg::*;

  localparam int AW = 16;
  localparam int LW = 8;
  localparam int WB = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          miss_detected;
  logic [AW-1:0] miss_address;
  logic          memory_data_valid;

  logic          busy0, busy1, req0, req1, wda0, wda1, tag0, tag1;
  logic [AW-1:0] addr0, addr1;
  logic [2:0]    sel0, sel1;
  fill_state_e   dbg0, dbg1;

  cache_fill_ctrl #(.ADDR_W(AW), .LINE_WORDS(LW), .WORD_BYTES(WB), .CWF(0)) dut0 (
    .clk(clk), .rst(rst), .miss_detected(miss_detected), .miss_address(miss_address),
    .memory_data_valid(memory_data_valid), .fsm_busy(busy0), .memory_address(addr0),
    .mem_req(req0), .write_data_array(wda0), .data_word_sel(sel0),
    .write_tag_array(tag0), .dbg_state(dbg0)
  );

  cache_fill_ctrl #(.ADDR_W(AW), .LINE_WORDS(LW), .WORD_BYTES(WB), .CWF(1)) dut1 (
    .clk(clk), .rst(rst), .miss_detected(miss_detected), .miss_address(miss_address),
    .memory_data_valid(memory_data_valid), .fsm_busy(busy1), .memory_address(addr1),
    .mem_req(req1), .write_data_array(wda1), .data_word_sel(sel1),
    .write_tag_array(tag1), .dbg_state(dbg1)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A fill is tracked as: phase (0 idle, 1 fetching, 2 tag write), line base,
  // critical word, and how many requests/responses have happened so far.
  int m_phase, m_base, m_crit, m_nreq, m_nresp;

  always @(posedge clk) cyc++;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0; m_base = 0; m_crit = 0; m_nreq = 0; m_nresp = 0;
    end else if (m_phase == 0) begin
      if (miss_detected) begin
        m_phase = 1;
        m_base  = int'(miss_address) - (int'(miss_address) % (LW * WB));
        m_crit  = (int'(miss_address) / WB) % LW;
        m_nreq  = 0;
        m_nresp = 0;
      end
    end else if (m_phase == 1) begin
      if (m_nreq < LW) m_nreq++;
      if (memory_data_valid && m_nresp < LW) begin
        m_nresp++;
        if (m_nresp == LW) m_phase = 2;
      end
    end else begin
      m_phase = 0;
    end
  end

  // ---------------- scoreboard logs / memory model ----------------
  int lat = 4;
  int gap_mode = 0;
  int spur_en = 0;
  int pend_q[$];
  logic [AW-1:0] alog0[$], alog1[$];
  int slog0[$], slog1[$];
  int rcyc0[$];
  int tag_cyc0[$];
  int tags1;

  task automatic cmp_dut(input int i, input logic busy, input logic req, input logic [AW-1:0] addr,
                         input logic wda, input logic [2:0] sel, input logic tag);
    int start;
    logic e_req, e_wda;
    int e_addr;
    start  = (i == 1) ? m_crit : 0;
    e_req  = (m_phase == 1) && (m_nreq < LW);
    e_addr = e_req ? m_base + ((start + m_nreq) % LW) * WB : 0;
    e_wda  = (m_phase == 1) && memory_data_valid && (m_nresp < LW);
    chk($sformatf("dut%0d fsm_busy", i), busy, m_phase != 0);
    chk($sformatf("dut%0d mem_req", i), req, e_req);
    chk($sformatf("dut%0d memory_address", i), addr, e_addr);
    chk($sformatf("dut%0d write_data_array", i), wda, e_wda);
    if (e_wda) chk($sformatf("dut%0d data_word_sel", i), sel, (start + m_nresp) % LW);
    chk($sformatf("dut%0d write_tag_array", i), tag, m_phase == 2);
  endtask

  always @(negedge clk) begin
    cmp_dut(0, busy0, req0, addr0, wda0, sel0, tag0);
    cmp_dut(1, busy1, req1, addr1, wda1, sel1, tag1);
    if (m_phase == 1 && m_nreq < LW) pend_q.push_back(cyc + lat);
    if (req0) begin alog0.push_back(addr0); rcyc0.push_back(cyc); end
    if (req1) alog1.push_back(addr1);
    if (wda0) slog0.push_back(int'(sel0));
    if (wda1) slog1.push_back(int'(sel1));
    if (tag0) tag_cyc0.push_back(cyc);
    if (tag1) tags1++;
  end

  // ---------------- driver tasks ----------------
  task automatic drive_mem();
    logic ok;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        pend_q.delete();
        memory_data_valid = 1'b0;
      end else begin
        ok = (pend_q.size() > 0) && (pend_q[0] <= cyc);
        if (gap_mode == 1) ok = ok && (cyc % 2 == 0);
        if (gap_mode == 2) ok = ok && ($urandom_range(0, 2) != 0);
        if (ok) void'(pend_q.pop_front());
        if (!ok && spur_en != 0 && m_phase != 1 && $urandom_range(0, 3) == 0) ok = 1'b1;
        memory_data_valid = ok;
      end
    end
  endtask

  task automatic do_miss(input logic [AW-1:0] a);
    @(posedge clk);
    #1 miss_detected = 1'b1;
    miss_address = a;
    @(posedge clk);
    #1 miss_detected = 1'b0;
    miss_address = AW'($urandom);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (m_phase != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (m_phase != 0) chk("wait_idle timeout", 1, 0);
  endtask

  task automatic wait_phase2(input int budget);
    int n = 0;
    while (m_phase != 2 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (m_phase != 2) chk("wait_done timeout", 1, 0);
  endtask

  task automatic clear_logs();
    alog0.delete(); alog1.delete(); slog0.delete(); slog1.delete();
    rcyc0.delete(); tag_cyc0.delete(); tags1 = 0;
  endtask

  // ---------------- main sequence ----------------
  int exp_a[8] = '{16'h123A, 16'h123C, 16'h123E, 16'h1230, 16'h1232, 16'h1234, 16'h1236, 16'h1238};
  int exp_s[8] = '{5, 6, 7, 0, 1, 2, 3, 4};

  initial begin
    rst = 1'b1;
    miss_detected = 1'b0;
    miss_address = '0;
    memory_data_valid = 1'b0;
    tags1 = 0;
    fork drive_mem(); join_none

    repeat (3) @(negedge clk);
    chk("reset fsm_busy", busy0, 0);
    chk("reset mem_req", req0, 0);
    chk("reset memory_address", addr0, 0);
    chk("reset write_tag_array", tag1, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Ascending fill, fixed latency 4.
    lat = 4; gap_mode = 0;
    clear_logs();
    do_miss(16'h1236);
    wait_idle(100);
    chk("asc busy low after tag", busy0, 0);
    chk("asc request count", alog0.size(), 8);
    for (int k = 0; k < 8 && k < alog0.size(); k++) chk("asc address", alog0[k], 16'h1230 + 2 * k);
    chk("asc write count", slog0.size(), 8);
    for (int k = 0; k < 8 && k < slog0.size(); k++) chk("asc slot", slog0[k], k);
    chk("asc tag pulses", tag_cyc0.size(), 1);
    if (rcyc0.size() == 8) chk("asc back-to-back", rcyc0[7] - rcyc0[0], 7);
    if (tag_cyc0.size() == 1) chk("asc busy falls next cycle", cyc - tag_cyc0[0], 1);
    if (alog1.size() > 0) chk("cwf first address 0x1236", alog1[0], 16'h1236);

    // Critical word first ordering.
    clear_logs();
    do_miss(16'h123A);
    wait_idle(100);
    chk("cwf request count", alog1.size(), 8);
    for (int k = 0; k < 8 && k < alog1.size(); k++) chk("cwf address", alog1[k], exp_a[k]);
    chk("cwf write count", slog1.size(), 8);
    for (int k = 0; k < 8 && k < slog1.size(); k++) chk("cwf slot", slog1[k], exp_s[k]);
    chk("cwf tag pulses", tags1, 1);

    // Responses on alternate cycles only.
    lat = 1; gap_mode = 1;
    clear_logs();
    do_miss(16'h2000);
    wait_idle(100);
    chk("gap request count", alog0.size(), 8);
    if (rcyc0.size() == 8) chk("gap back-to-back", rcyc0[7] - rcyc0[0], 7);
    chk("gap write count", slog0.size(), 8);
    chk("gap tag pulses", tag_cyc0.size(), 1);
    if (tag_cyc0.size() == 1 && rcyc0.size() > 0)
      chk("gap tag delayed", (tag_cyc0[0] - rcyc0[0]) >= 16, 1);

    // Mid-fill miss ignored; miss right after DONE starts with no bubble.
    lat = 4; gap_mode = 0;
    clear_logs();
    do_miss(16'h3000);
    repeat (3) @(negedge clk);
    do_miss(16'h4440);
    wait_phase2(100);
    @(posedge clk);
    #1 miss_detected = 1'b1;
    miss_address = 16'h4440;
    @(posedge clk);
    #1 miss_detected = 1'b0;
    wait_idle(100);
    chk("b2b request count", alog0.size(), 16);
    if (alog0.size() == 16) begin
      chk("b2b first fill end", alog0[7], 16'h300E);
      chk("b2b second fill base", alog0[8], 16'h4440);
    end
    chk("b2b tag pulses", tag_cyc0.size(), 2);
    if (tag_cyc0.size() > 0 && rcyc0.size() == 16) chk("b2b no bubble", rcyc0[8] - tag_cyc0[0], 2);

    // Asynchronous reset in the middle of a fill.
    lat = 2;
    clear_logs();
    do_miss(16'h5550);
    begin
      int n = 0;
      while (m_nresp < 3 && n < 100) begin @(negedge clk); n++; end
      if (m_nresp < 3) chk("wait 3 responses timeout", 1, 0);
    end
    #2 rst = 1'b1;
    #1;
    chk("async rst fsm_busy", busy0, 0);
    chk("async rst mem_req", req0, 0);
    chk("async rst memory_address", addr0, 0);
    chk("async rst write_data_array", wda0, 0);
    chk("async rst busy cwf", busy1, 0);
    chk("async rst address cwf", addr1, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    clear_logs();
    do_miss(16'h0010);
    wait_idle(100);
    chk("post-rst request count", alog0.size(), 8);
    if (alog0.size() > 0) chk("post-rst first address", alog0[0], 16'h0010);
    if (alog1.size() > 0) chk("post-rst cwf first address", alog1[0], 16'h0010);
    chk("post-rst write count", slog0.size(), 8);
    chk("post-rst tag pulses", tag_cyc0.size(), 1);

    // Randomized fills with spurious valids, mid-fill misses and resets.
    spur_en = 1;
    for (int t = 0; t < 30; t++) begin
      lat = $urandom_range(1, 6);
      gap_mode = $urandom_range(0, 2);
      do_miss(AW'($urandom));
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(0, 5)) @(negedge clk);
        do_miss(AW'($urandom));
      end
      if ($urandom_range(0, 4) == 0) begin
        repeat ($urandom_range(1, 8)) @(negedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
      end
      wait_idle(200);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_fill_ctrl.md
CACHE_FILL_CTRL -- requirements
Module: cache_fill_ctrl

Interface
REQ-001 Parameter ADDR_W, default 16: byte-address width.
REQ-002 Parameter LINE_WORDS, default 8: words per cache line; power of two, at least 2.
REQ-003 Parameter WORD_BYTES, default 2: bytes per word; power of two.
REQ-004 Parameter CWF, default 0: 1 selects critical-word-first fetch order, 0 selects ascending order from word 0.
REQ-005 clk  input  1  sole clock; all state changes on the rising edge.
REQ-006 rst  input  1  reset; asynchronous and active-high.
REQ-007 miss_detected  input  1  tag-match logic reports a miss this cycle.
REQ-008 miss_address  input  ADDR_W  byte address that missed.
REQ-009 memory_data_valid  input  1  one returned word is valid on the memory bus this cycle.
REQ-010 fsm_busy  output  1  a fill is in progress; used as the pipeline stall.
REQ-011 memory_address  output  ADDR_W  word address currently requested from memory.
REQ-012 mem_req  output  1  memory_address is a valid request this cycle.
REQ-013 write_data_array  output  1  write the returned word into the data array.
REQ-014 data_word_sel  output  log2(LINE_WORDS)  word slot that write_data_array targets.
REQ-015 write_tag_array  output  1  single-cycle pulse: line complete, write the tag.

Function
REQ-016 States SHALL be IDLE, FILL and DONE.
REQ-017 IDLE->FILL when miss_detected=1; the same edge SHALL latch miss_address into the line base and the start word index.
REQ-018 In FILL, the block SHALL assert mem_req one word per cycle until LINE_WORDS requests have issued; requests SHALL NOT wait for returned data.
REQ-019 memory_address SHALL be {latched line base, request word index, log2(WORD_BYTES) zero bits}.
REQ-020 Request word index: with CWF=0, SHALL run 0..LINE_WORDS-1; with CWF=1, SHALL start at the missed word and wrap modulo LINE_WORDS.
REQ-021 A separate response counter SHALL advance only on memory_data_valid; in that cycle write_data_array=1 and data_word_sel=(start index + response count) mod LINE_WORDS, so responses are in issue order.
REQ-022 FILL->DONE on the cycle the LINE_WORDS-th response is accepted.
REQ-023 DONE SHALL last exactly one cycle with write_tag_array=1, then return to IDLE.
REQ-024 fsm_busy SHALL be 1 in FILL and DONE and 0 in IDLE.
REQ-025 miss_detected SHALL be ignored outside IDLE; miss_address is sampled only on the IDLE->FILL edge.
REQ-026 memory_data_valid SHALL be ignored in IDLE and DONE, and after all responses are counted.
REQ-027 mem_req SHALL be 0 once all requests have issued, even while responses are still pending.
REQ-028 Counters SHALL be log2(LINE_WORDS)+1 bits wide so that a count of LINE_WORDS is representable.
REQ-029 A miss in the IDLE cycle immediately after DONE SHALL start a new fill with no bubble.

Reset
REQ-030 Asserting rst SHALL force IDLE immediately, including in the middle of a fill; all outputs go to 0, memory_address goes to 0, and the counters and latched address are cleared.
REQ-031 After rst is released, the first miss SHALL behave exactly as a miss that follows a normal fill; no state from the aborted fill remains.

Structure
REQ-032 The state enum and the derived widths (word-index width, offset width) SHALL live in a shared package, cache_pkg.
REQ-033 The request and response counters SHALL be two instances of one sub-module, wrap_counter (enable, clear, count, wrapped index).

Verification
REQ-034 Defaults, CWF=0, miss at 0x1236, valid returned 4 cycles after each request -> addresses 0x1230, 0x1232 ... 0x123E on 8 consecutive cycles; 8 writes to slots 0..7; write_tag_array pulses once; fsm_busy falls on the following cycle.
REQ-035 CWF=1, miss at 0x123A -> request order 0x123A, 0x123C, 0x123E, 0x1230 ... 0x1238; data_word_sel sequence 5,6,7,0,1,2,3,4.
REQ-036 Gaps in memory_data_valid (valid on alternate cycles) -> all 8 requests still issue back-to-back, 8 writes occur, write_tag_array is delayed accordingly.
REQ-037 Second miss at 0x4440 asserted mid-fill -> ignored; a miss at 0x4440 in the first cycle after DONE -> the fill starts the next cycle with base 0x4440.
REQ-038 rst asserted after 3 responses -> outputs 0 with no clock edge needed; a new miss at 0x0010 -> a clean 8-word fill and a single tag pulse.
